legv8_instr_encoder: RTL

//  Encodes field-level requests (op, register numbers, immediate) into 32-bit LEGv8 instruction

---
 rtl/legv8_instr_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
//   Turns field-level requests (op, register numbers, signed immediate) into
//   32-bit LEGv8 instruction words. The words are queued in a small FIFO and
//   streamed out with a running byte address for the instruction-memory loader.
//   Requests whose immediate does not fit the target field are still
//   handshaken. They are dropped, and the drop is reported on err_pulse and
//   err_count.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   clr                   synchronous flush (err_count is kept)
//   in_valid / in_ready   request handshake
//   op, rd, rn, rm, imm   request fields (op: ADD SUB AND ORR LDUR STUR CBZ B)
//   out_valid / out_ready output handshake
//   out_word, out_addr    encoded word at FIFO head and its byte address
//   err_pulse, err_count  dropped-request pulse and saturating count
module legv8_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [63:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_B    = 3'd7
  } op_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   last_word;
  logic [31:0]   enc_word;
  logic          imm_ok;
  logic          accept, push, pop, reject;

  // Encoder and immediate range check. Fields an op does not use never reach the word.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    enc_word = '0;
    imm_ok   = 1'b1;
    case (op_e'(op))
      OP_ADD:  enc_word = {11'b10001011000, rm, 6'b0, rn, rd};
      OP_SUB:  enc_word = {11'b11001011000, rm, 6'b0, rn, rd};
      OP_AND:  enc_word = {11'b10001010000, rm, 6'b0, rn, rd};
      OP_ORR:  enc_word = {11'b10101010000, rm, 6'b0, rn, rd};
      OP_LDUR, OP_STUR: begin
        enc_word = {(op == 3'd4) ? 11'd1986 : 11'd1984, imm[8:0], 2'b00, rn, rd};
        // The value fits in 9 signed bits when every higher bit matches the sign bit.
        imm_ok   = (imm[25:8] == {18{imm[8]}});
      end
      OP_CBZ: begin
        enc_word = {8'd180, imm[18:0], rd};
        imm_ok   = (imm[25:18] == {8{imm[18]}});
      end
      OP_B:    enc_word = {6'd5, imm};
      default: enc_word = '0;
    endcase
  end

  // in_ready uses only the registered occupancy. A pop in the same cycle does
  // not free a slot until the next cycle.
  assign in_ready  = rst_n && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready && !clr;
  assign push      = accept && imm_ok;
  assign reject    = accept && !imm_ok;
  assign pop       = out_valid && out_ready && !clr;

  // When the FIFO is empty, out_word shows the last word that left it.
  assign out_word  = out_valid ? mem[rd_ptr] : last_word;

  // NOTE: the storage array has no reset. Occupancy is tracked by count, so
  // stale entries are never visible, and leaving out the reset lets the array
  // map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_addr  <= BASE_ADDR;
      last_word <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_addr  <= BASE_ADDR;
      err_pulse <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_addr  <= out_addr + 64'd4;
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      err_pulse <= reject;
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
